// File: rtl/scs_mem_arbiter_if.sv
// Bus between the three packet-RAM masters and scs_mem_arbiter.
// Per-master fields are packed master i at [i*W +: W].
interface scs_mem_arbiter_if #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
);
    logic [2:0]                   req;
    logic [2:0]                   rel;
    logic [2:0]                   we;
    logic [3*RAM_ADDR_BITS-1:0]   addr;
    logic [3*RAM_WIDTH-1:0]       wdata;
    logic [2:0]                   grant;
    logic                         ram_we;
    logic [RAM_ADDR_BITS-1:0]     ram_addr;
    logic [RAM_WIDTH-1:0]         ram_din;
    logic                         busy;
    logic [1:0]                   owner;
    logic                         timeout;

    modport slave (
        input  req, rel, we, addr, wdata,
        output grant, ram_we, ram_addr, ram_din, busy, owner, timeout
    );

    modport master (
        output req, rel, we, addr, wdata,
        input  grant, ram_we, ram_addr, ram_din, busy, owner, timeout
    );
endinterface

// File: rtl/scs_mem_arbiter.sv
// Round-robin burst arbiter sharing one single-port packet RAM between
// loader (0), scs checksum engine (1) and transmitter (2).
module scs_mem_arbiter #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10,
    parameter int MAX_HOLD      = 2048,
    parameter int HOLD_BITS     = 12
) (
    input logic             clock,
    input logic             reset,
    scs_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    state_t                   state, state_n;
    logic [2:0]               grant_q, grant_n;
    logic                     busy_q, busy_n;
    logic [1:0]               owner_q, owner_n;
    logic [1:0]               rr_ptr_q, rr_ptr_n;
    logic                     timeout_q, timeout_n;
    logic [HOLD_BITS-1:0]     hold_q, hold_n;

    logic [RAM_ADDR_BITS-1:0] addr_sel, addr_last;
    logic [RAM_WIDTH-1:0]     din_sel, din_last;
    logic                     we_sel;
    logic                     rel_own;
    logic                     any_req;
    logic [1:0]               pick;

    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            idx = 2'((32'(ptr) + i) % 3);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [1:0] next_ptr(input logic [1:0] k);
        next_ptr = (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

    assign any_req = |bus.req;
    assign pick    = rr_pick(bus.req, rr_ptr_q);

    always_comb begin
        addr_sel = bus.addr[0 +: RAM_ADDR_BITS];
        din_sel  = bus.wdata[0 +: RAM_WIDTH];
        we_sel   = bus.we[0] & grant_q[0];
        rel_own  = bus.rel[0];
        case (owner_q)
            2'd1: begin
                addr_sel = bus.addr[RAM_ADDR_BITS +: RAM_ADDR_BITS];
                din_sel  = bus.wdata[RAM_WIDTH +: RAM_WIDTH];
                we_sel   = bus.we[1] & grant_q[1];
                rel_own  = bus.rel[1];
            end
            2'd2: begin
                addr_sel = bus.addr[2*RAM_ADDR_BITS +: RAM_ADDR_BITS];
                din_sel  = bus.wdata[2*RAM_WIDTH +: RAM_WIDTH];
                we_sel   = bus.we[2] & grant_q[2];
                rel_own  = bus.rel[2];
            end
            default: ;
        endcase
    end

    // The dead GAP cycle also samples req, so a waiting master is granted
    // immediately after it; rr_ptr is already advanced when GAP is entered.
    always_comb begin
        state_n   = state;
        grant_n   = grant_q;
        busy_n    = busy_q;
        owner_n   = owner_q;
        rr_ptr_n  = rr_ptr_q;
        timeout_n = 1'b0;
        hold_n    = hold_q;
        case (state)
            IDLE, GAP: begin
                hold_n  = '0;
                state_n = IDLE;
                if (any_req) begin
                    state_n = OWN;
                    grant_n = 3'b001 << pick;
                    busy_n  = 1'b1;
                    owner_n = pick;
                end
            end
            OWN: begin
                if (rel_own || hold_q == HOLD_BITS'(MAX_HOLD - 1)) begin
                    state_n   = GAP;
                    grant_n   = '0;
                    busy_n    = 1'b0;
                    hold_n    = '0;
                    rr_ptr_n  = next_ptr(owner_q);
                    timeout_n = !rel_own;
                end else begin
                    hold_n = hold_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            addr_last <= '0;
            din_last  <= '0;
        end else begin
            state     <= state_n;
            grant_q   <= grant_n;
            busy_q    <= busy_n;
            owner_q   <= owner_n;
            rr_ptr_q  <= rr_ptr_n;
            timeout_q <= timeout_n;
            hold_q    <= hold_n;
            if (state == OWN) begin
                addr_last <= addr_sel;
                din_last  <= din_sel;
            end
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.timeout  = timeout_q;
    assign bus.ram_we   = (state == OWN) && we_sel;
    assign bus.ram_addr = (state == OWN) ? addr_sel : addr_last;
    assign bus.ram_din  = (state == OWN) ? din_sel : din_last;

endmodule
